// File: rtl/prog_sequencer.sv
`timescale 1ns/1ps
// Run controller for the 9-bit core: pulses Start with a program base address,
// waits for halt/timeout/abort, and reports status over a four-phase Req/Done handshake.
//
// state | meaning
// IDLE  | waiting for Req; Status/CycleCount from the last run are held
// START | CoreStart high for START_CYC cycles; CoreAck ignored
// RUN   | counting cycles until halt, abort or watchdog expiry
// DONE  | Done high until the host drops Req
module prog_sequencer #(
  parameter int            CW        = 16,
  parameter logic [CW-1:0] TMO       = 16'hFFFF,
  parameter int            START_CYC = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Req,
  input  logic [1:0]    ProgSel,
  input  logic          Abort,
  input  logic          CoreAck,
  output logic          CoreStart,
  output logic [9:0]    StartAddr,
  output logic          Busy,
  output logic          Done,
  output logic [1:0]    Status,
  output logic [CW-1:0] CycleCount,
  output logic [7:0]    RunCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ST_NONE  = 2'b00;
  localparam logic [1:0] ST_OK    = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  // Start pulse timer counts down to zero; loaded with START_CYC-1 on entry.
  localparam logic [3:0] START_LOAD = 4'(START_CYC - 1);

  state_t        state;
  logic [1:0]    selReg;
  logic [3:0]    startCnt;
  logic [CW-1:0] cycleNext;

  assign cycleNext = CycleCount + {{(CW-1){1'b0}}, 1'b1};
  assign StartAddr = {selReg, 8'h00};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      selReg     <= 2'b00;
      startCnt   <= 4'd0;
      CoreStart  <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Status     <= ST_NONE;
      CycleCount <= '0;
      RunCount   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Req) begin
            state      <= START;
            selReg     <= ProgSel;
            startCnt   <= START_LOAD;
            CycleCount <= '0;
            Status     <= ST_NONE;
            CoreStart  <= 1'b1;
            Busy       <= 1'b1;
          end
        end
        START: begin
          if (Abort) begin
            state     <= DONE;
            CoreStart <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            Status    <= ST_ABORT;
            RunCount  <= RunCount + 8'd1;
          end else if (startCnt == 4'd0) begin
            state     <= RUN;
            CoreStart <= 1'b0;
          end else begin
            startCnt <= startCnt - 4'd1;
          end
        end
        RUN: begin
          if (Abort) begin
            state    <= DONE;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            Status   <= ST_ABORT;
            RunCount <= RunCount + 8'd1;
          end else if (CoreAck) begin
            state    <= DONE;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            Status   <= ST_OK;
            RunCount <= RunCount + 8'd1;
          end else begin
            // Watchdog compares the incremented value, so the count stops exactly at TMO.
            CycleCount <= cycleNext;
            if (cycleNext == TMO) begin
              state    <= DONE;
              Busy     <= 1'b0;
              Done     <= 1'b1;
              Status   <= ST_TMO;
              RunCount <= RunCount + 8'd1;
            end
          end
        end
        DONE: begin
          if (!Req) begin
            state <= IDLE;
            Done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for prog_sequencer: each run pushes its expected completion record,
// a monitor pops and compares it when Done rises.
module tb_prog_sequencer;

  localparam int          CW  = 16;
  localparam logic [15:0] TMO = 16'd10;
  localparam int          SC  = 2;

  logic        Clk = 1'b0;
  logic        Reset, Req, Abort, CoreAck;
  logic [1:0]  ProgSel;
  logic        CoreStart, Busy, Done;
  logic [9:0]  StartAddr;
  logic [1:0]  Status;
  logic [15:0] CycleCount;
  logic [7:0]  RunCount;

  prog_sequencer #(.CW(CW), .TMO(TMO), .START_CYC(SC)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ProgSel(ProgSel), .Abort(Abort),
    .CoreAck(CoreAck), .CoreStart(CoreStart), .StartAddr(StartAddr), .Busy(Busy),
    .Done(Done), .Status(Status), .CycleCount(CycleCount), .RunCount(RunCount)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int nPass = 0;
  int nTotal = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [1:0]  st;
    logic [15:0] cc;
    logic [7:0]  rc;
    logic [9:0]  addr;
    int          doneCyc;
  } exp_t;

  exp_t q[$];
  logic doneQ = 1'b0;
  exp_t e;

  always @(negedge Clk) begin
    if (Done && !doneQ && !Reset) begin
      if (q.size() == 0) begin
        nTotal++;
        $display("FAIL unexpected_done: Done rose at cycle %0d with no run pending", cyc);
      end else begin
        e = q.pop_front();
        chk("mon_status", 32'(Status), 32'(e.st));
        chk("mon_cycle_count", 32'(CycleCount), 32'(e.cc));
        chk("mon_run_count", 32'(RunCount), 32'(e.rc));
        chk("mon_start_addr", 32'(StartAddr), 32'(e.addr));
        chk("mon_done_cycle", 32'(cyc), 32'(e.doneCyc));
      end
    end
    doneQ <= Done;
  end

  logic [7:0] rcModel;

  // abortRun: -1 = abort in first START cycle, 0 = none, k = abort on RUN cycle k.
  // ackRun: 0 = never, k = CoreAck high from RUN cycle k onward.
  task automatic doRun(input logic [1:0] sel, input int ackRun, input int abortRun,
                       input bit ackEarly, input int holdN, input bit wiggle);
    int k, lat, n;
    logic [1:0] st;
    logic [15:0] cc;
    bit seen;
    exp_t x;
    if (abortRun < 0) begin
      st = 2'b11; cc = 16'd0; lat = 1;
    end else begin
      k = int'(TMO);
      if (ackRun > 0 && ackRun <= k) k = ackRun;
      if (abortRun > 0 && abortRun <= k) k = abortRun;
      if (abortRun > 0 && abortRun == k) st = 2'b11;
      else if (ackRun > 0 && ackRun == k) st = 2'b01;
      else st = 2'b10;
      cc = (st == 2'b10) ? TMO : 16'(k - 1);
      lat = SC + k;
    end
    rcModel = rcModel + 8'd1;
    if (ackEarly) begin
      CoreAck = 1'b1;
      @(negedge Clk);
    end
    Req = 1'b1;
    ProgSel = sel;
    @(negedge Clk);
    n = cyc;
    x.st = st; x.cc = cc; x.rc = rcModel; x.addr = {sel, 8'h00}; x.doneCyc = n + lat;
    q.push_back(x);
    chk("start_addr", 32'(StartAddr), 32'({sel, 8'h00}));
    seen = 1'b0;
    for (int j = 0; j < 60; j++) begin
      if (Done) begin
        seen = 1'b1;
        break;
      end
      chk("core_start", 32'(CoreStart), 32'(j < SC));
      chk("busy", 32'(Busy), 32'd1);
      k = j - SC + 1;
      Abort = (abortRun == -1 && j == 0) || (abortRun > 0 && k == abortRun);
      CoreAck = ackEarly || (ackRun > 0 && k >= ackRun);
      if (wiggle && j == 1) begin
        Req = 1'b0;
        ProgSel = ~sel;
      end
      @(negedge Clk);
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_core_start_low", 32'(CoreStart), 32'd0);
    Abort = 1'b0;
    CoreAck = 1'b0;
    for (int h = 0; h < holdN; h++) begin
      @(negedge Clk);
      chk("done_held", 32'(Done), 32'd1);
      chk("busy_in_done", 32'(Busy), 32'd0);
    end
    Req = 1'b0;
    @(negedge Clk);
    chk("idle_done_low", 32'(Done), 32'd0);
    chk("idle_status_held", 32'(Status), 32'(st));
    chk("idle_count_held", 32'(CycleCount), 32'(cc));
    @(negedge Clk);
  endtask

  task automatic chkResetVals(input string tag);
    chk({tag, "_core_start"}, 32'(CoreStart), 32'd0);
    chk({tag, "_start_addr"}, 32'(StartAddr), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_done"}, 32'(Done), 32'd0);
    chk({tag, "_status"}, 32'(Status), 32'd0);
    chk({tag, "_cycle_count"}, 32'(CycleCount), 32'd0);
    chk({tag, "_run_count"}, 32'(RunCount), 32'd0);
  endtask

  initial begin
    Reset = 1'b1; Req = 1'b0; Abort = 1'b0; CoreAck = 1'b0; ProgSel = 2'd0;
    rcModel = 8'd0;
    repeat (3) @(negedge Clk);
    chkResetVals("reset");
    Reset = 1'b0;
    @(negedge Clk);

    doRun(2'd2, 5, 0, 1'b0, 0, 1'b0);
    doRun(2'd1, 1, 0, 1'b1, 0, 1'b0);
    doRun(2'd3, 0, 0, 1'b0, 0, 1'b0);
    doRun(2'd0, 3, 3, 1'b0, 0, 1'b0);
    doRun(2'd1, 0, -1, 1'b0, 0, 1'b0);
    doRun(2'd2, 4, 0, 1'b0, 3, 1'b0);
    doRun(2'd1, 6, 0, 1'b0, 0, 1'b1);

    // Reset in the middle of a run
    Req = 1'b1;
    ProgSel = 2'd3;
    @(negedge Clk);
    Req = 1'b0;
    repeat (SC + 7) @(negedge Clk);
    chk("midrun_cycle_count", 32'(CycleCount), 32'd7);
    chk("midrun_busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    chkResetVals("midrun_reset");
    Reset = 1'b0;
    rcModel = 8'd0;
    @(negedge Clk);
    chk("post_reset_idle_busy", 32'(Busy), 32'd0);

    doRun(2'd2, 5, 0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 255; i++) doRun(2'(i), 0, -1, 1'b0, 0, 1'b0);
    chk("run_count_wrap", 32'(RunCount), 32'd0);

    repeat (3) @(negedge Clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
